// File: rtl/unary_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unary_pkg
// Purpose  : Shared constants, FSM state encoding and thermometer-code helper
//            functions for the unary state encoder and its reference model.
// Contents : N_LEDS, ST_W      - unary word width / state width
//            state_t, S_*      - FSM state encoding
//            thermo_valid()    - word is a (possibly empty) thermometer code
//            popcount()        - number of set bits in a word
// Revision : 1.0 - initial release
// ============================================================================
package unary_pkg;

   // N_LEDS must stay equal to 2**ST_W - 1 so a full word's count fits ST_W.
   localparam int N_LEDS = 15;
   localparam int ST_W   = 4;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_CHECK = 2'd1;
   localparam state_t S_TRACK = 2'd2;

   // A thermometer code 0..01..1 plus one is a single power of two, so the
   // AND is zero. The extra top bit keeps all-ones from wrapping to zero
   // ambiguously and lets all-zeros through as well.
   function automatic logic thermo_valid(input logic [N_LEDS-1:0] w);
      logic [N_LEDS:0] e;
      e = {1'b0, w};
      return ((e & (e + (N_LEDS+1)'(1))) == '0);
   endfunction

   function automatic logic [ST_W-1:0] popcount(input logic [N_LEDS-1:0] w);
      logic [ST_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         c = c + {{(ST_W-1){1'b0}}, w[i]};
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/unary_state_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : unary_state_encoder_if
// Purpose  : Word handshake, step tick and status bundle of the unary state
//            encoder.
// Signals  : IN_VALID/IN_READY - word handshake
//            UNARY, BTN        - thermometer word and its polarity
//            STEP              - step tick
//            ST, TARGET        - tracked and target state
//            BUSY, ERR, DONE   - status
// Modports : master - word source / status consumer
//            slave  - the encoder
// Revision : 1.0 - initial release
// ============================================================================
interface unary_state_encoder_if #(
   parameter int N_LEDS = unary_pkg::N_LEDS,
   parameter int ST_W   = unary_pkg::ST_W
);
   logic              IN_VALID;
   logic              IN_READY;
   logic [N_LEDS-1:0] UNARY;
   logic              BTN;
   logic              STEP;
   logic [ST_W-1:0]   ST;
   logic [ST_W-1:0]   TARGET;
   logic              BUSY;
   logic              ERR;
   logic              DONE;

   modport master (
      output IN_VALID, UNARY, BTN, STEP,
      input  IN_READY, ST, TARGET, BUSY, ERR, DONE
   );

   modport slave (
      input  IN_VALID, UNARY, BTN, STEP,
      output IN_READY, ST, TARGET, BUSY, ERR, DONE
   );
endinterface
`default_nettype wire

// File: rtl/unary_state_encoder_thermo_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : thermo_to_bin
// Purpose  : Combinational thermometer-word checker and counter.
// Ports    : i_word  - captured (polarity-corrected) unary word
//            o_valid - word is a thermometer code
//            o_count - number of lit LEDs
// Revision : 1.0 - initial release
// ============================================================================
module thermo_to_bin #(
   parameter int N_LEDS = unary_pkg::N_LEDS,
   parameter int ST_W   = unary_pkg::ST_W
) (
   input  logic [N_LEDS-1:0] i_word,
   output logic              o_valid,
   output logic [ST_W-1:0]   o_count
);
   import unary_pkg::*;

   assign o_valid = thermo_valid(i_word);
   assign o_count = popcount(i_word);

endmodule
`default_nettype wire

// File: rtl/unary_state_encoder.sv
`default_nettype none
// ============================================================================
// Module   : unary_state_encoder
// Purpose  : Captures a unary (thermometer) word, checks it, converts it to a
//            target state and walks ST toward it one step per STEP tick.
// Ports    : CLK   - clock, rising edge
//            RST_N - synchronous active-low reset
//            bus   - slave side of unary_state_encoder_if (handshake, word,
//                    step tick, ST/TARGET, BUSY/ERR/DONE)
// Revision : 1.0 - initial release
// ============================================================================
module unary_state_encoder #(
   parameter int N_LEDS = unary_pkg::N_LEDS,
   parameter int ST_W   = unary_pkg::ST_W
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   unary_state_encoder_if.slave  bus
);
   import unary_pkg::*;

   localparam logic [ST_W-1:0] c_st_one = ST_W'(1);

   state_t            r_state;
   state_t            w_next_state;
   logic [N_LEDS-1:0] r_word;
   logic [ST_W-1:0]   r_st;
   logic [ST_W-1:0]   r_target;
   logic              r_err;
   logic              r_done;
   logic              w_valid;
   logic [ST_W-1:0]   w_count;
   logic [ST_W-1:0]   w_st_step;
   logic              w_in_ready;
   logic              w_busy;

   thermo_to_bin #(
      .N_LEDS (N_LEDS),
      .ST_W   (ST_W)
   ) u_thermo_to_bin (
      .i_word  (r_word),
      .o_valid (w_valid),
      .o_count (w_count)
   );

   // TRACK is only entered with ST != TARGET, so this never wraps.
   assign w_st_step = (r_st < r_target) ? (r_st + c_st_one) : (r_st - c_st_one);

   // State register
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.IN_VALID) begin
               w_next_state = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_valid && (w_count != r_st)) begin
               w_next_state = S_TRACK;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_TRACK: begin
            if (bus.STEP && (w_st_step == r_target)) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_in_ready = (r_state == S_IDLE);
      w_busy     = (r_state == S_CHECK) || (r_state == S_TRACK);
   end

   // Capture, target and tracked-state registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_word   <= '0;
         r_st     <= '0;
         r_target <= '0;
         r_err    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.IN_VALID) begin
                  r_word <= bus.BTN ? bus.UNARY : ~bus.UNARY;
               end
            end
            S_CHECK: begin
               if (w_valid) begin
                  r_target <= w_count;
                  r_err    <= 1'b0;
                  r_done   <= (w_count == r_st);
               end else begin
                  // Bubble: keep the last good target and ST untouched.
                  r_err <= 1'b1;
               end
            end
            S_TRACK: begin
               if (bus.STEP) begin
                  r_st   <= w_st_step;
                  r_done <= (w_st_step == r_target);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.IN_READY = w_in_ready;
   assign bus.BUSY     = w_busy;
   assign bus.ST       = r_st;
   assign bus.TARGET   = r_target;
   assign bus.ERR      = r_err;
   assign bus.DONE     = r_done;

endmodule
`default_nettype wire

// File: doc/unary_state_encoder.md
# unary_state_encoder

Receive end of the stone-age unary LED code: accepts a 15-bit thermometer word (true or complemented, selected by BTN), checks it, and converts it to a 4-bit target state. A tracked state register `ST` then walks one step per `STEP` tick toward that target. It sits between the switch/input capture logic and the counter FSM, and is the inverse of the state-to-unary output decoder. Its `ST` output can drive that decoder directly for loop-back checking.

## Interface
Parameters:
- `N_LEDS`, 15: unary word width. Must equal 2^`ST_W` − 1.
- `ST_W`, 4: state width.

Ports:
- `CLK`, in, 1: single clock. All logic is rising-edge.
- `RST_N`, in, 1: reset, synchronous, active-low.
- `IN_VALID`, in, 1: `UNARY`/`BTN` are offered.
- `IN_READY`, out, 1: block can accept a word. High only in IDLE.
- `UNARY`, in, `N_LEDS`: thermometer word, bit 0 = first LED.
- `BTN`, in, 1: word polarity. 1 = true code; 0 = complemented code (invert on capture).
- `STEP`, in, 1: step tick. One `ST` move per cycle it is high, in TRACK only.
- `ST`, out, `ST_W`: tracked state.
- `TARGET`, out, `ST_W`: last valid decoded count.
- `BUSY`, out, 1: high in CHECK and TRACK.
- `ERR`, out, 1: last checked word was not a thermometer code.
- `DONE`, out, 1: one-cycle pulse when `ST` reaches `TARGET`.

## Operation
- **FSM states:** IDLE, CHECK, TRACK. Reset forces IDLE.
- **IDLE:**
  - `IN_READY`=1.
  - On `IN_VALID`&`IN_READY`, capture w = `BTN` ? `UNARY` : ~`UNARY`, then go to CHECK.
  - `STEP` is ignored.
- **CHECK** (exactly one cycle), `IN_READY`=0:
  - w is valid iff (w & (w+1)) == 0, evaluated at `N_LEDS`+1 bits. This admits all-zeros through all-ones.
  - Valid word:
    - `TARGET` ← popcount(w), which fits `ST_W` with no overflow.
    - `ERR` ← 0.
    - If popcount == `ST`: `DONE` pulses and the FSM goes to IDLE.
    - Otherwise the FSM goes to TRACK.
  - Invalid word (bubble):
    - `ERR` ← 1.
    - `TARGET` and `ST` are unchanged.
    - No `DONE`.
    - FSM goes to IDLE.
- **TRACK:**
  - On each cycle with `STEP`=1: `ST` ← `ST`+1 if `ST` < `TARGET`, else `ST`−1.
  - On the edge where `ST` becomes `TARGET`, the FSM goes to IDLE, `DONE`=1 for the following cycle, and `ST`==`TARGET` holds in that same cycle.
  - `IN_VALID` is ignored (not accepted and not queued).
- **ERR** is sticky. It changes only at the next CHECK.
- **No wrap-around:** `ST` is always between old `ST` and `TARGET`. `ST` never passes 0 or 2^`ST_W`−1.

## Timing
- **Reset values:** `ST`=0, `TARGET`=0, `ERR`=0, `DONE`=0, `BUSY`=0, `IN_READY`=1 in the first cycle after `RST_N` returns high.
- **Reset mid-operation** (CHECK or TRACK): the word is abandoned, all outputs go to reset values, and no `DONE` is produced.
- **Handshake:** a word is accepted on the edge where `IN_VALID`&`IN_READY`.
- **Latency, accept at edge t:**
  - CHECK occupies the cycle after t.
  - Decision is made at edge t+1.
  - Same-target or invalid word: `DONE`/`ERR` are visible and `IN_READY`=1 again from t+1.
  - Otherwise, `ST` reaches `TARGET` after |`TARGET`−`ST`| `STEP` cycles.
- **STEP held high:** one move per cycle. With `STEP` high throughout, the minimum accept-to-`DONE` time is 1 + |Δ| cycles.
- **Outputs:** all registered. No combinational path from inputs to outputs except `IN_READY`, which is decoded from the FSM state only.

## Structure
- **Shared package `unary_pkg`:**
  - `N_LEDS` and `ST_W` constants.
  - FSM state typedef/encoding.
  - `thermo_valid` and `popcount` functions, also used by the bench reference model.
- **One sub-module: `thermo_to_bin`.** Purely combinational: w → {valid, count}. Instantiated once; the CHECK state registers its outputs.
- **Top level:** holds the capture register, the FSM, and the `ST`/`TARGET` registers.

## Test plan
1. Reset: hold `RST_N`=0 for 3 cycles with random inputs → `ST`=0, `TARGET`=0, `ERR`=0, `DONE`=0, `BUSY`=0, `IN_READY`=1.
2. From `ST`=0, `BTN`=1, `UNARY`=15'h001F, `STEP` held 1 → `TARGET`=5; `ST` steps 1,2,3,4,5 on successive cycles; `DONE` high one cycle with `ST`=5; `IN_READY`=1 again.
3. From `ST`=5, `BTN`=0, `UNARY`=15'h7FF8 → `TARGET`=3; `ST` goes 5→4→3 and holds during `STEP`=0 gaps; `DONE` once.
4. Bubble: `BTN`=1, `UNARY`=15'h0005 → `ERR`=1 one cycle after accept; `TARGET`/`ST` unchanged; no `DONE`; `IN_VALID` pulsed during CHECK is not accepted.
5. Same target: `ST`=3, `UNARY`=15'h0007 → `DONE` one cycle after accept, `BUSY` high one cycle, `ERR` cleared from a prior 1.
6. Extremes/reset: from 0, `UNARY`=15'h7FFF with `STEP` every 4th cycle; pull `RST_N` low when `ST`=6 → `ST`=0, no `DONE`. Then `UNARY`=15'h0000 → `TARGET`=0 and immediate `DONE`.
